// File: rtl/uart.sv
// rtl/uart.sv - 8N1 UART with 16x oversampling baud generator and RX/TX byte FIFOs
module uart_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full
);
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(2**AW));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

module uart #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    input  logic        rd_uart,
    output logic [7:0]  r_data,
    input  logic        wr_uart,
    input  logic [7:0]  w_data,
    input  logic [31:0] dvsr,
    output logic        rx_empty,
    output logic        full,
    output logic        tx_full
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = $clog2(DBIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [32:0]   baud_cnt, baud_limit;
    logic          tick;
    logic [1:0]    rx_sync;
    logic          rx_s;
    state_t        rx_state, tx_state;
    logic [SW-1:0] rx_s_cnt, tx_s_cnt;
    logic [NW-1:0] rx_n, tx_n;
    logic [7:0]    rx_b, tx_b, rx_head, tx_head;
    logic          rx_done, tx_reg, tx_empty, tx_pop, tx_stop_end;

    assign baud_limit = {dvsr, 1'b1};
    assign tick       = (baud_cnt == baud_limit);

    always_ff @(posedge clk) begin
        if (reset)                      baud_cnt <= '0;
        else if (baud_cnt >= baud_limit) baud_cnt <= '0;
        else                            baud_cnt <= baud_cnt + 33'd1;
    end

    // rx is asynchronous to clk; two flops before the FSM looks at it.
    always_ff @(posedge clk) begin
        if (reset) rx_sync <= 2'b11;
        else       rx_sync <= {rx_sync[0], rx};
    end
    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_s_cnt <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (rx_state)
                IDLE: if (!rx_s) begin
                    rx_state <= START;
                    rx_s_cnt <= '0;
                end
                START: if (tick) begin
                    if (rx_s_cnt == SW'(7)) begin
                        rx_s_cnt <= '0;
                        rx_n     <= '0;
                        rx_state <= rx_s ? IDLE : DATA;
                    end else rx_s_cnt <= rx_s_cnt + 1'b1;
                end
                DATA: if (tick) begin
                    if (rx_s_cnt == SW'(15)) begin
                        rx_s_cnt <= '0;
                        rx_b     <= {rx_s, rx_b[7:1]};
                        if (rx_n == NW'(DBIT-1)) rx_state <= STOP;
                        else                     rx_n <= rx_n + 1'b1;
                    end else rx_s_cnt <= rx_s_cnt + 1'b1;
                end
                STOP: if (tick) begin
                    if (rx_s_cnt == SW'(SB_TICK-1)) begin
                        rx_state <= IDLE;
                        rx_s_cnt <= '0;
                        rx_done  <= rx_s;
                    end else rx_s_cnt <= rx_s_cnt + 1'b1;
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    uart_fifo #(.DW(8), .AW(FIFO_AW)) rx_fifo (
        .clk(clk), .reset(reset), .push(rx_done), .wdata(rx_b), .pop(rd_uart),
        .rdata(rx_head), .empty(rx_empty), .full(full)
    );

    always_ff @(posedge clk) begin
        if (reset)                     r_data <= '0;
        else if (rd_uart && !rx_empty) r_data <= rx_head;
    end

    // Popping at the end of a stop bit chains frames without an idle gap.
    assign tx_stop_end = (tx_state == STOP) && tick && (tx_s_cnt == SW'(SB_TICK-1));
    assign tx_pop      = ((tx_state == IDLE) || tx_stop_end) && !tx_empty;

    uart_fifo #(.DW(8), .AW(FIFO_AW)) tx_fifo (
        .clk(clk), .reset(reset), .push(wr_uart), .wdata(w_data), .pop(tx_pop),
        .rdata(tx_head), .empty(tx_empty), .full(tx_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_s_cnt <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_reg   <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!tx_empty) begin
                        tx_state <= START;
                        tx_s_cnt <= '0;
                        tx_b     <= tx_head;
                        tx_reg   <= 1'b0;
                    end
                end
                START: if (tick) begin
                    if (tx_s_cnt == SW'(15)) begin
                        tx_state <= DATA;
                        tx_s_cnt <= '0;
                        tx_n     <= '0;
                        tx_reg   <= tx_b[0];
                    end else tx_s_cnt <= tx_s_cnt + 1'b1;
                end
                DATA: if (tick) begin
                    if (tx_s_cnt == SW'(15)) begin
                        tx_s_cnt <= '0;
                        tx_b     <= {1'b0, tx_b[7:1]};
                        if (tx_n == NW'(DBIT-1)) begin
                            tx_state <= STOP;
                            tx_reg   <= 1'b1;
                        end else begin
                            tx_n   <= tx_n + 1'b1;
                            tx_reg <= tx_b[1];
                        end
                    end else tx_s_cnt <= tx_s_cnt + 1'b1;
                end
                STOP: if (tick) begin
                    if (tx_s_cnt == SW'(SB_TICK-1)) begin
                        tx_s_cnt <= '0;
                        if (!tx_empty) begin
                            tx_state <= START;
                            tx_b     <= tx_head;
                            tx_reg   <= 1'b0;
                        end else tx_state <= IDLE;
                    end else tx_s_cnt <= tx_s_cnt + 1'b1;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    assign tx = tx_reg;
endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - randomized self-checking bench for uart against a queue-based reference model
module tb_uart;
    logic        clk = 1'b0;
    logic        reset, rx_line, loopback, rd_uart, wr_uart;
    logic [7:0]  w_data, r_data;
    logic [31:0] dvsr;
    logic        tx, rx_empty, full, tx_full, rx_pin;

    assign rx_pin = loopback ? tx : rx_line;

    uart dut (
        .clk(clk), .reset(reset), .rx(rx_pin), .tx(tx), .rd_uart(rd_uart),
        .r_data(r_data), .wr_uart(wr_uart), .w_data(w_data), .dvsr(dvsr),
        .rx_empty(rx_empty), .full(full), .tx_full(tx_full)
    );

    always #5 clk = ~clk;

    int         n_pass = 0, n_fail = 0, n_total = 0;
    logic [7:0] rx_model[$];
    int         cyc = 0;
    int         tx_edges[$];
    logic       tx_prev = 1'b1;

    // Timestamp every tx transition, in clock cycles.
    always @(negedge clk) begin
        cyc++;
        if (tx !== tx_prev) tx_edges.push_back(cyc);
        tx_prev = tx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int bit_clks();
        return 32 * (int'(dvsr) + 1);
    endfunction

    task automatic send_frame(input logic [7:0] d, output logic empty_at_stop);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        empty_at_stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            if (i == 9) empty_at_stop = rx_empty;
            tick_n(bit_clks());
        end
        rx_line = 1'b1;
        if (rx_model.size() < 16) rx_model.push_back(d);
    endtask

    task automatic pop_expect(input string tag);
        logic [7:0] e;
        e = rx_model.pop_front();
        rd_uart = 1'b1;
        tick_n(1);
        rd_uart = 1'b0;
        check(tag, 32'(r_data), 32'(e));
    endtask

    task automatic tx_capture(input string tag, input logic [7:0] exp);
        logic [9:0] f;
        int waited, b;
        b = bit_clks();
        waited = 0;
        while (tx !== 1'b0 && waited < 40 * b) begin
            tick_n(1);
            waited++;
        end
        if (tx !== 1'b0) begin
            check({tag, "_timeout"}, 32'(tx), 32'(0));
            return;
        end
        tick_n(b / 2);
        for (int i = 0; i < 10; i++) begin
            f[i] = tx;
            if (i < 9) tick_n(b);
        end
        check(tag, 32'(f), 32'({1'b1, exp, 1'b0}));
    endtask

    // Every edge after the start bit's closing edge must land on a whole bit period.
    task automatic check_bit_len(input string tag);
        int bad, b;
        bad = 0;
        b = bit_clks();
        for (int k = 2; k < tx_edges.size(); k++) begin
            if (((tx_edges[k] - tx_edges[k-1]) % b) != 0) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        logic       flag;
        logic [7:0] e;
        logic [7:0] bytes[18];
        logic [9:0] f;
        int         lows;

        reset = 1'b1; rx_line = 1'b1; loopback = 1'b0; rd_uart = 1'b0;
        wr_uart = 1'b0; w_data = '0; dvsr = '0;
        tick_n(2);
        reset = 1'b0;
        check("rst_tx", 32'(tx), 1);
        check("rst_r_data", 32'(r_data), 0);
        check("rst_rx_empty", 32'(rx_empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_tx_full", 32'(tx_full), 0);

        send_frame(8'hA5, flag);
        check("rx_a5_empty_at_stop", 32'(flag), 1);
        check("rx_a5_empty_after", 32'(rx_empty), 0);
        e = rx_model.pop_front();
        rd_uart = 1'b1;
        tick_n(32);
        rd_uart = 1'b0;
        check("rx_a5_r_data_hold", 32'(r_data), 32'(e));
        check("rx_a5_drained", 32'(rx_empty), 1);

        tx_edges.delete();
        w_data = 8'h3C; wr_uart = 1'b1;
        tick_n(1);
        wr_uart = 1'b0;
        tx_capture("tx_3c", 8'h3C);
        tick_n(bit_clks());
        check("tx_3c_idle_after", 32'(tx), 1);
        check("tx_3c_edge_count", tx_edges.size(), 4);
        check_bit_len("tx_3c_bit_len");

        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), flag);
            if (i == 14) check("rx_not_full_15", 32'(full), 0);
            if (i == 15) check("rx_full_16", 32'(full), 1);
        end
        check("rx_full_17", 32'(full), 1);
        for (int i = 0; i < 16; i++) pop_expect($sformatf("rx_fifo_%0d", i));
        check("rx_fifo_drained", 32'(rx_empty), 1);
        check("rx_fifo_not_full", 32'(full), 0);

        rx_line = 1'b0;
        tick_n(5);
        rx_line = 1'b1;
        tick_n(100);
        check("false_start_empty", 32'(rx_empty), 1);

        for (int i = 0; i < 6; i++) begin
            send_frame(8'($urandom), flag);
            tick_n($urandom_range(0, 40));
            pop_expect($sformatf("rx_rand_%0d", i));
        end

        for (int i = 0; i < 18; i++) bytes[i] = 8'($urandom);
        tx_edges.delete();
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    w_data = bytes[i]; wr_uart = 1'b1;
                    tick_n(1);
                    if (i == 15) check("tx_not_full_16", 32'(tx_full), 0);
                    if (i == 16) check("tx_full_17", 32'(tx_full), 1);
                end
                wr_uart = 1'b0;
            end
            begin
                for (int i = 0; i < 17; i++) tx_capture($sformatf("tx_burst_%0d", i), bytes[i]);
            end
        join
        lows = 0;
        repeat (3 * bit_clks()) begin
            tick_n(1);
            if (tx === 1'b0) lows++;
        end
        check("tx_burst_18th_dropped", lows, 0);
        check_bit_len("tx_burst_bit_len");

        dvsr = 32'd3; loopback = 1'b1;
        tick_n(10);
        tx_edges.delete();
        w_data = 8'h55; wr_uart = 1'b1;
        tick_n(1);
        wr_uart = 1'b0;
        tx_capture("tx_55_dvsr3", 8'h55);
        rx_model.push_back(8'h55);
        tick_n(bit_clks());
        check("bit_period_dvsr3", tx_edges[2] - tx_edges[1], 128);
        check_bit_len("tx_55_bit_len");
        pop_expect("loopback_55");
        loopback = 1'b0; dvsr = '0;
        tick_n(10);

        f = {1'b1, 8'h5A, 1'b0};
        w_data = 8'hF0; wr_uart = 1'b1; rx_line = f[0];
        tick_n(1);
        wr_uart = 1'b0;
        tick_n(31);
        for (int i = 1; i < 4; i++) begin
            rx_line = f[i];
            tick_n(32);
        end
        rx_line = f[4];
        tick_n(16);
        reset = 1'b1; rx_line = 1'b1;
        tick_n(1);
        check("midrst_tx", 32'(tx), 1);
        check("midrst_rx_empty", 32'(rx_empty), 1);
        check("midrst_tx_full", 32'(tx_full), 0);
        check("midrst_r_data", 32'(r_data), 0);
        tick_n(1);
        reset = 1'b0;
        lows = 0;
        repeat (400) begin
            tick_n(1);
            if (tx === 1'b0) lows++;
        end
        check("midrst_no_tx", lows, 0);
        check("midrst_no_rx", 32'(rx_empty), 1);
        send_frame(8'h81, flag);
        pop_expect("rx_81_after_reset");
        check("final_rx_empty", 32'(rx_empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
